// File: rtl/mem_arbiter.sv
// Two-client block memory arbiter: serialises I-cache and D-cache block
// transactions onto one memory port with round-robin or data-first priority.
module mem_arbiter #(
    parameter int ADDR_W        = 28,
    parameter int DATA_W        = 128,
    parameter int PRIORITY_MODE = 0
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              req_read_I,
    input  logic              req_write_I,
    input  logic [ADDR_W-1:0] req_addr_I,
    input  logic [DATA_W-1:0] req_wdata_I,
    output logic [DATA_W-1:0] req_rdata_I,
    output logic              req_ready_I,
    input  logic              req_read_D,
    input  logic              req_write_D,
    input  logic [ADDR_W-1:0] req_addr_D,
    input  logic [DATA_W-1:0] req_wdata_D,
    output logic [DATA_W-1:0] req_rdata_D,
    output logic              req_ready_D,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              grant_I,
    output logic              grant_D
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic                last_d_r;       // 1'b0: I-cache won last, 1'b1: D-cache won last
    logic                pend_i_s;
    logic                pend_d_s;
    logic                pick_d_s;
    logic                start_s;
    logic                sel_read_s;
    logic                sel_write_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic                mem_read_r;
    logic                mem_write_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;

    assign pend_i_s    = req_read_I | req_write_I;
    assign pend_d_s    = req_read_D | req_write_D;
    assign sel_read_s  = pick_d_s ? req_read_D  : req_read_I;
    assign sel_write_s = pick_d_s ? req_write_D : req_write_I;
    assign sel_addr_s  = pick_d_s ? req_addr_D  : req_addr_I;
    assign sel_wdata_s = pick_d_s ? req_wdata_D : req_wdata_I;

    // Winner selection and next-state logic
    always_comb begin
        pick_d_s     = 1'b0;
        start_s      = 1'b0;
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (pend_i_s && pend_d_s) begin
                    if (PRIORITY_MODE == 32'sd1) begin
                        pick_d_s = 1'b1;
                    end else begin
                        pick_d_s = ~last_d_r;
                    end
                end else begin
                    pick_d_s = pend_d_s;
                end
                if (pend_i_s || pend_d_s) begin
                    start_s      = 1'b1;
                    state_next_s = pick_d_s ? GRANT_D : GRANT_I;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, fairness pointer and memory-side request snapshot
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_r     <= IDLE;
            last_d_r    <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (start_s) begin
                // write has precedence when a client raises both strobes
                mem_read_r  <= sel_read_s & ~sel_write_s;
                mem_write_r <= sel_write_s;
                mem_addr_r  <= sel_addr_s;
                mem_wdata_r <= sel_wdata_s;
                last_d_r    <= pick_d_s;
            end else if ((state_r != IDLE) && mem_ready) begin
                mem_read_r  <= 1'b0;
                mem_write_r <= 1'b0;
            end
        end
    end

    assign mem_read    = mem_read_r;
    assign mem_write   = mem_write_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign grant_I     = (state_r == GRANT_I);
    assign grant_D     = (state_r == GRANT_D);
    assign req_ready_I = (state_r == GRANT_I) & mem_ready;
    assign req_ready_D = (state_r == GRANT_D) & mem_ready;
    assign req_rdata_I = mem_rdata;
    assign req_rdata_D = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a round-robin instance (u0) and a
// data-first instance (u1) driven with shared request stimulus.
module tb_mem_arbiter;

    logic         clk;
    logic         rst;
    logic         rd_i, wr_i, rd_d, wr_d;
    logic [27:0]  a_i, a_d;
    logic [127:0] wd_i, wd_d, mem_rdata;
    logic         mrdy [2];

    logic         gi [2], gd [2], mrd_o [2], mwr_o [2], ryi [2], ryd [2];
    logic [27:0]  ma_o [2];
    logic [127:0] mwd_o [2], rdi_o [2], rdd_o [2];

    // behavioural reference: owner 0 = none, 1 = I, 2 = D
    int           own [2];
    bit           lastd [2];
    logic         e_rd [2], e_wr [2];
    logic [27:0]  e_ad [2];
    logic [127:0] e_wd [2];

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        rd_i, wr_i;
        logic [27:0] a_i;
        logic        rd_d, wr_d;
        logic [27:0] a_d;
        logic        mr;
        logic        gi, gd, mrd, mwr;
        logic [27:0] ma;
        logic        ri, rdy_d;
    } vec_t;

    vec_t vecs [22];

    mem_arbiter #(.ADDR_W(28), .DATA_W(128), .PRIORITY_MODE(0)) u0 (
        .clk(clk), .proc_reset(rst),
        .req_read_I(rd_i), .req_write_I(wr_i), .req_addr_I(a_i), .req_wdata_I(wd_i),
        .req_rdata_I(rdi_o[0]), .req_ready_I(ryi[0]),
        .req_read_D(rd_d), .req_write_D(wr_d), .req_addr_D(a_d), .req_wdata_D(wd_d),
        .req_rdata_D(rdd_o[0]), .req_ready_D(ryd[0]),
        .mem_read(mrd_o[0]), .mem_write(mwr_o[0]), .mem_addr(ma_o[0]), .mem_wdata(mwd_o[0]),
        .mem_rdata(mem_rdata), .mem_ready(mrdy[0]), .grant_I(gi[0]), .grant_D(gd[0]));

    mem_arbiter #(.ADDR_W(28), .DATA_W(128), .PRIORITY_MODE(1)) u1 (
        .clk(clk), .proc_reset(rst),
        .req_read_I(rd_i), .req_write_I(wr_i), .req_addr_I(a_i), .req_wdata_I(wd_i),
        .req_rdata_I(rdi_o[1]), .req_ready_I(ryi[1]),
        .req_read_D(rd_d), .req_write_D(wr_d), .req_addr_D(a_d), .req_wdata_D(wd_d),
        .req_rdata_D(rdd_o[1]), .req_ready_D(ryd[1]),
        .mem_read(mrd_o[1]), .mem_write(mwr_o[1]), .mem_addr(ma_o[1]), .mem_wdata(mwd_o[1]),
        .mem_rdata(mem_rdata), .mem_ready(mrdy[1]), .grant_I(gi[1]), .grant_D(gd[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic ri_, logic wi_, logic [27:0] ai_, logic rdd_, logic wdd_,
                                logic [27:0] ad_, logic mr_, logic egi, logic egd, logic emr,
                                logic emw, logic [27:0] ema, logic eri, logic erd);
        vec_t v;
        v.rd_i = ri_; v.wr_i = wi_; v.a_i = ai_; v.rd_d = rdd_; v.wr_d = wdd_; v.a_d = ad_;
        v.mr = mr_; v.gi = egi; v.gd = egd; v.mrd = emr; v.mwr = emw; v.ma = ema;
        v.ri = eri; v.rdy_d = erd;
        return v;
    endfunction

    task automatic chk(input string nm, input int m, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d actual=%h required=%h", nm, m, act, exp);
        end
    endtask

    // sample outputs mid-cycle and compare both instances with the model
    task automatic settle();
        #4;
        for (int m = 0; m < 2; m++) begin
            chk("grant_I", m, gi[m], own[m] == 1);
            chk("grant_D", m, gd[m], own[m] == 2);
            chk("ready_I", m, ryi[m], (own[m] == 1) && mrdy[m]);
            chk("ready_D", m, ryd[m], (own[m] == 2) && mrdy[m]);
            chk("mem_read", m, mrd_o[m], e_rd[m]);
            chk("mem_write", m, mwr_o[m], e_wr[m]);
            chk("mem_addr", m, ma_o[m], e_ad[m]);
            chk("mem_wdata", m, mwd_o[m], e_wd[m]);
            chk("rdata_I", m, rdi_o[m], mem_rdata);
            chk("rdata_D", m, rdd_o[m], mem_rdata);
        end
    endtask

    // advance the reference by one clock, then step past the edge
    task automatic advance();
        bit pi, pd, wdn;
        pi = rd_i | wr_i;
        pd = rd_d | wr_d;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                own[m] = 0; lastd[m] = 1'b0; e_rd[m] = 1'b0; e_wr[m] = 1'b0;
                e_ad[m] = 28'd0; e_wd[m] = 128'd0;
            end else if (own[m] == 0) begin
                if (pi || pd) begin
                    if (pi && pd) wdn = (m == 1) ? 1'b1 : !lastd[m];
                    else          wdn = pd;
                    own[m]   = wdn ? 2 : 1;
                    lastd[m] = wdn;
                    e_wr[m]  = wdn ? wr_d : wr_i;
                    e_rd[m]  = (wdn ? rd_d : rd_i) && !e_wr[m];
                    e_ad[m]  = wdn ? a_d : a_i;
                    e_wd[m]  = wdn ? wd_d : wd_i;
                end
            end else if (mrdy[m]) begin
                own[m] = 0; e_rd[m] = 1'b0; e_wr[m] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rd_i = 1'b0; wr_i = 1'b0; rd_d = 1'b0; wr_d = 1'b0;
        mrdy[0] = 1'b0; mrdy[1] = 1'b0;
        advance();
        advance();
        rst = 1'b0;
    endtask

    initial begin
        logic [127:0] w;
        bit done_i, done_d;
        a_i = 28'd0; a_d = 28'd0; wd_i = 128'd0; wd_d = 128'd0;
        mem_rdata = {16{8'hA5}};
        do_reset();
        settle();
        advance();

        vecs[0]  = mk(1'b0,1'b0,28'h10,1'b0,1'b0,28'h30,1'b0, 1'b0,1'b0,1'b0,1'b0,28'h0, 1'b0,1'b0);
        vecs[1]  = mk(1'b1,1'b0,28'h10,1'b0,1'b0,28'h30,1'b0, 1'b0,1'b0,1'b0,1'b0,28'h0, 1'b0,1'b0);
        vecs[2]  = mk(1'b1,1'b0,28'h10,1'b0,1'b0,28'h30,1'b0, 1'b1,1'b0,1'b1,1'b0,28'h10,1'b0,1'b0);
        vecs[3]  = vecs[2];
        vecs[4]  = vecs[2];
        vecs[5]  = vecs[2];
        vecs[6]  = mk(1'b1,1'b0,28'h10,1'b0,1'b0,28'h30,1'b1, 1'b1,1'b0,1'b1,1'b0,28'h10,1'b1,1'b0);
        vecs[7]  = mk(1'b0,1'b0,28'h10,1'b0,1'b0,28'h30,1'b0, 1'b0,1'b0,1'b0,1'b0,28'h10,1'b0,1'b0);
        vecs[8]  = mk(1'b0,1'b0,28'h10,1'b0,1'b0,28'h30,1'b1, 1'b0,1'b0,1'b0,1'b0,28'h10,1'b0,1'b0);
        vecs[9]  = mk(1'b1,1'b0,28'h20,1'b1,1'b0,28'h30,1'b0, 1'b0,1'b0,1'b0,1'b0,28'h10,1'b0,1'b0);
        vecs[10] = mk(1'b1,1'b0,28'h20,1'b1,1'b0,28'h30,1'b0, 1'b0,1'b1,1'b1,1'b0,28'h30,1'b0,1'b0);
        vecs[11] = mk(1'b1,1'b0,28'h20,1'b1,1'b0,28'h30,1'b1, 1'b0,1'b1,1'b1,1'b0,28'h30,1'b0,1'b1);
        vecs[12] = mk(1'b1,1'b0,28'h20,1'b0,1'b0,28'h30,1'b0, 1'b0,1'b0,1'b0,1'b0,28'h30,1'b0,1'b0);
        vecs[13] = mk(1'b1,1'b0,28'h20,1'b0,1'b0,28'h30,1'b0, 1'b1,1'b0,1'b1,1'b0,28'h20,1'b0,1'b0);
        vecs[14] = mk(1'b1,1'b0,28'h20,1'b0,1'b0,28'h30,1'b1, 1'b1,1'b0,1'b1,1'b0,28'h20,1'b1,1'b0);
        vecs[15] = mk(1'b1,1'b0,28'h20,1'b1,1'b0,28'h30,1'b0, 1'b0,1'b0,1'b0,1'b0,28'h20,1'b0,1'b0);
        vecs[16] = mk(1'b1,1'b0,28'h20,1'b1,1'b0,28'h30,1'b0, 1'b0,1'b1,1'b1,1'b0,28'h30,1'b0,1'b0);
        vecs[17] = mk(1'b1,1'b0,28'h20,1'b1,1'b0,28'h30,1'b1, 1'b0,1'b1,1'b1,1'b0,28'h30,1'b0,1'b1);
        vecs[18] = mk(1'b1,1'b0,28'h20,1'b0,1'b0,28'h30,1'b0, 1'b0,1'b0,1'b0,1'b0,28'h30,1'b0,1'b0);
        vecs[19] = mk(1'b1,1'b0,28'h20,1'b0,1'b0,28'h30,1'b0, 1'b1,1'b0,1'b1,1'b0,28'h20,1'b0,1'b0);
        vecs[20] = mk(1'b1,1'b0,28'h20,1'b0,1'b0,28'h30,1'b1, 1'b1,1'b0,1'b1,1'b0,28'h20,1'b1,1'b0);
        vecs[21] = mk(1'b0,1'b0,28'h20,1'b0,1'b0,28'h30,1'b0, 1'b0,1'b0,1'b0,1'b0,28'h20,1'b0,1'b0);

        for (int k = 0; k < 22; k++) begin
            rd_i = vecs[k].rd_i; wr_i = vecs[k].wr_i; a_i = vecs[k].a_i;
            rd_d = vecs[k].rd_d; wr_d = vecs[k].wr_d; a_d = vecs[k].a_d;
            mrdy[0] = vecs[k].mr; mrdy[1] = vecs[k].mr;
            settle();
            chk("tbl_grant_I", 0, gi[0], vecs[k].gi);
            chk("tbl_grant_D", 0, gd[0], vecs[k].gd);
            chk("tbl_mem_read", 0, mrd_o[0], vecs[k].mrd);
            chk("tbl_mem_write", 0, mwr_o[0], vecs[k].mwr);
            chk("tbl_mem_addr", 0, ma_o[0], vecs[k].ma);
            chk("tbl_ready_I", 0, ryi[0], vecs[k].ri);
            chk("tbl_ready_D", 0, ryd[0], vecs[k].rdy_d);
            if (vecs[k].ri) chk("tbl_rdata_I", 0, rdi_o[0], {16{8'hA5}});
            advance();
        end

        // D write: a mid-transaction wdata change must not reach memory
        w = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        wr_d = 1'b1; a_d = 28'h0ABCDEF; wd_d = w;
        settle(); advance();
        wd_d = ~w;
        settle();
        for (int m = 0; m < 2; m++) begin
            chk("wr_hold_write", m, mwr_o[m], 1'b1);
            chk("wr_hold_addr", m, ma_o[m], 28'h0ABCDEF);
            chk("wr_hold_wdata", m, mwd_o[m], w);
        end
        advance();
        mrdy[0] = 1'b1; mrdy[1] = 1'b1;
        settle();
        for (int m = 0; m < 2; m++) begin
            chk("wr_ready_D", m, ryd[m], 1'b1);
            chk("wr_wdata_end", m, mwd_o[m], w);
        end
        advance();
        wr_d = 1'b0; mrdy[0] = 1'b0; mrdy[1] = 1'b0;
        settle();
        for (int m = 0; m < 2; m++) begin
            chk("wr_done_write", m, mwr_o[m], 1'b0);
            chk("wr_done_wdata", m, mwd_o[m], w);
        end
        advance();

        // reset while I owns the memory, then an immediate re-grant
        rd_i = 1'b1; a_i = 28'h0000040;
        settle(); advance();
        settle(); chk("rst_pre_grant_I", 0, gi[0], 1'b1); advance();
        rst = 1'b1;
        settle(); advance();
        rst = 1'b0;
        settle();
        chk("rst_grant_I", 0, gi[0], 1'b0);
        chk("rst_mem_read", 0, mrd_o[0], 1'b0);
        chk("rst_mem_addr", 0, ma_o[0], 28'h0);
        advance();
        settle();
        chk("rst_regrant_I", 0, gi[0], 1'b1);
        chk("rst_regrant_read", 0, mrd_o[0], 1'b1);
        chk("rst_regrant_addr", 0, ma_o[0], 28'h0000040);
        advance();
        mrdy[0] = 1'b1; mrdy[1] = 1'b1;
        settle(); chk("rst_ready_I", 0, ryi[0], 1'b1); advance();
        rd_i = 1'b0; mrdy[0] = 1'b0; mrdy[1] = 1'b0;
        settle(); advance();

        // data-first instance: D's write-back and allocate both precede I
        do_reset();
        rd_i = 1'b1; a_i = 28'h0000100; wr_d = 1'b1; a_d = 28'h1234567; wd_d = w;
        settle(); chk("pri_idle0", 1, gd[1], 1'b0); advance();
        settle();
        chk("pri_wb_grant", 1, gd[1], 1'b1);
        chk("pri_wb_write", 1, mwr_o[1], 1'b1);
        chk("pri_wb_addr", 1, ma_o[1], 28'h1234567);
        advance();
        mrdy[0] = 1'b1; mrdy[1] = 1'b1;
        settle(); chk("pri_wb_ready", 1, ryd[1], 1'b1); chk("pri_wb_ready_I", 1, ryi[1], 1'b0); advance();
        mrdy[0] = 1'b0; mrdy[1] = 1'b0; wr_d = 1'b0; rd_d = 1'b1; a_d = 28'h2345678;
        settle();
        chk("pri_gap1_D", 1, gd[1], 1'b0);
        chk("pri_gap1_I", 1, gi[1], 1'b0);
        chk("pri_gap1_read", 1, mrd_o[1], 1'b0);
        advance();
        settle();
        chk("pri_al_grant", 1, gd[1], 1'b1);
        chk("pri_al_read", 1, mrd_o[1], 1'b1);
        chk("pri_al_addr", 1, ma_o[1], 28'h2345678);
        advance();
        mrdy[0] = 1'b1; mrdy[1] = 1'b1;
        settle(); chk("pri_al_ready", 1, ryd[1], 1'b1); advance();
        mrdy[0] = 1'b0; mrdy[1] = 1'b0; rd_d = 1'b0;
        settle(); chk("pri_gap2_I", 1, gi[1], 1'b0); chk("pri_gap2_D", 1, gd[1], 1'b0); advance();
        settle(); chk("pri_i_grant", 1, gi[1], 1'b1); chk("pri_i_addr", 1, ma_o[1], 28'h0000100); advance();
        mrdy[0] = 1'b1; mrdy[1] = 1'b1;
        settle(); chk("pri_i_ready", 1, ryi[1], 1'b1); advance();
        rd_i = 1'b0; mrdy[0] = 1'b0; mrdy[1] = 1'b0;
        settle(); advance();

        // randomized traffic against the reference model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 149) == 0);
            for (int m = 0; m < 2; m++) begin
                if (e_rd[m] || e_wr[m]) mrdy[m] = ($urandom_range(0, 3) == 0);
                else                    mrdy[m] = ($urandom_range(0, 9) == 0);
            end
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            settle();
            done_i = (own[0] == 1) && mrdy[0];
            done_d = (own[0] == 2) && mrdy[0];
            advance();
            if (rst || done_i) begin rd_i = 1'b0; wr_i = 1'b0; end
            if (rst || done_d) begin rd_d = 1'b0; wr_d = 1'b0; end
            if (!(rd_i || wr_i) && $urandom_range(0, 2) == 0) begin
                {wr_i, rd_i} = 2'($urandom_range(1, 3));
                a_i = 28'($urandom); wd_i = {$urandom, $urandom, $urandom, $urandom};
            end else if ($urandom_range(0, 7) == 0) begin
                a_i = 28'($urandom); wd_i = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!(rd_d || wr_d) && $urandom_range(0, 2) == 0) begin
                {wr_d, rd_d} = 2'($urandom_range(1, 3));
                a_d = 28'($urandom); wd_d = {$urandom, $urandom, $urandom, $urandom};
            end else if ($urandom_range(0, 7) == 0) begin
                a_d = 28'($urandom); wd_d = {$urandom, $urandom, $urandom, $urandom};
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
